// File: rtl/barrel_shift.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift
// Description : Registered rotate unit for the ALU datapath. Rotates an
//               N-bit operand right (ROR) or left (ROL) by 0..N-1 bits
//               through a log2(N)-stage combinational mux network. The
//               result is registered once, giving a latency of one clock.
// Ports       : clk       - system clock, rising-edge active
//               reset     - synchronous, active-high reset (clears y)
//               a         - operand to rotate            [WIDTH-1:0]
//               amt       - rotate distance, unsigned    [AMT_W-1:0]
//               direction - 0 = rotate right, 1 = rotate left
//               y         - registered rotate result     [WIDTH-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [AMT_W-1:0] amt,
   input  logic             direction,
   output logic [WIDTH-1:0] y
);

   localparam logic [AMT_W-1:0] c_one = AMT_W'(1);

   // The mux network only ever rotates right. A left rotate by k equals a
   // right rotate by (WIDTH-k) mod WIDTH, which is the two's-complement
   // negation of k in AMT_W bits (the modulo comes free from truncation).
   logic [AMT_W-1:0]         w_neg_amt;
   logic [AMT_W-1:0]         w_ror_amt;

   // w_stage[0] is the operand; w_stage[s+1] is the output of stage s.
   logic [AMT_W:0][WIDTH-1:0] w_stage;

   logic [WIDTH-1:0]         r_y;

   assign w_neg_amt  = (~amt) + c_one;
   assign w_ror_amt  = direction ? w_neg_amt : amt;
   assign w_stage[0] = a;

   // Stage s rotates right by 2^s when the matching amount bit is set:
   // the low c_shift bits wrap around to the top.
   genvar s;
   generate
      for (s = 0; s < AMT_W; s++) begin : g_stage
         localparam int c_shift = 1 << s;
         assign w_stage[s+1] = w_ror_amt[s]
                             ? {w_stage[s][c_shift-1:0], w_stage[s][WIDTH-1:c_shift]}
                             : w_stage[s];
      end
   endgenerate

   // Single output register; reset wins over the datapath.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_y <= '0;
      end else begin
         r_y <= w_stage[AMT_W];
      end
   end

   assign y = r_y;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shift
// Description : Self-checking bench for barrel_shift (WIDTH=8). Directed
//               vectors with hand-computed results, a back-to-back stream
//               and an exhaustive sweep against a behavioural rotate model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift;

   localparam int c_width = 8;
   localparam int c_amt_w = 3;

   logic               clk;
   logic               reset;
   logic [c_width-1:0] a;
   logic [c_amt_w-1:0] amt;
   logic               direction;
   logic [c_width-1:0] y;

   int n_checks;
   int n_errors;

   barrel_shift #(
      .WIDTH (c_width),
      .AMT_W (c_amt_w)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .a         (a),
      .amt       (amt),
      .direction (direction),
      .y         (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Behavioural rotate, bit by bit from the index definition.
   function automatic logic [c_width-1:0] ref_rot(input logic [c_width-1:0] v,
                                                 input int k, input logic left);
      logic [c_width-1:0] r;
      for (int i = 0; i < c_width; i++) begin
         if (left) r[i] = v[(i - k + c_width) % c_width];
         else      r[i] = v[(i + k) % c_width];
      end
      return r;
   endfunction

   // Drive one vector, clock it in, check one edge later.
   task automatic apply(input string tag, input logic [7:0] av, input logic [2:0] k,
                        input logic dir, input logic [7:0] exp);
      a = av; amt = k; direction = dir;
      @(posedge clk); #1;
      check(tag, 32'(y), 32'(exp));
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;

      // Reset holds y at zero regardless of inputs.
      reset = 1'b1; a = 8'hFF; amt = 3'd3; direction = 1'b0;
      @(posedge clk); #1;
      check("reset_edge1", 32'(y), 32'h00);
      @(posedge clk); #1;
      check("reset_edge2", 32'(y), 32'h00);
      reset = 1'b0;
      @(posedge clk); #1;
      check("first_after_reset", 32'(y), 32'hFF);

      // ROR by 4
      apply("ror4_99", 8'b10011001, 3'd4, 1'b0, 8'b10011001);
      apply("ror4_19", 8'b00011001, 3'd4, 1'b0, 8'b10010001);
      apply("ror4_c0", 8'b11000000, 3'd4, 1'b0, 8'b00001100);
      // Wrap-around single bit
      apply("ror1_81", 8'h81, 3'd1, 1'b0, 8'hC0);
      apply("rol1_81", 8'h81, 3'd1, 1'b1, 8'h03);
      apply("ror7_01", 8'h01, 3'd7, 1'b0, 8'h02);
      apply("rol7_01", 8'h01, 3'd7, 1'b1, 8'h80);
      // Zero amount and half-width symmetry
      apply("ror0_a5", 8'hA5, 3'd0, 1'b0, 8'hA5);
      apply("rol0_a5", 8'hA5, 3'd0, 1'b1, 8'hA5);
      apply("ror4_3c", 8'h3C, 3'd4, 1'b0, 8'hC3);
      apply("rol4_3c", 8'h3C, 3'd4, 1'b1, 8'hC3);
      // Other hand-computed values
      apply("rol3_96", 8'h96, 3'd3, 1'b1, 8'hB4);
      apply("ror2_96", 8'h96, 3'd2, 1'b0, 8'hA5);

      // Hold: same inputs re-register the same result.
      @(posedge clk); #1;
      check("hold", 32'(y), 32'hA5);

      // Mid-stream reset discards that cycle; next edge is valid again.
      a = 8'h12; amt = 3'd1; direction = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      check("midstream_reset", 32'(y), 32'h00);
      reset = 1'b0;
      @(posedge clk); #1;
      check("after_mid_reset", 32'(y), 32'h24);

      // Back-to-back random stream: new vector every cycle, no bubbles.
      for (int i = 0; i < 200; i++) begin
         logic [7:0] av;
         logic [2:0] k;
         logic       dir;
         av  = 8'($urandom_range(0, 255));
         k   = 3'($urandom_range(0, 7));
         dir = 1'($urandom_range(0, 1));
         a = av; amt = k; direction = dir;
         @(posedge clk); #1;
         check("stream", 32'(y), 32'(ref_rot(av, int'(k), dir)));
         if (dir)
            check("stream_rol_as_ror", 32'(y), 32'(ref_rot(av, (8 - int'(k)) % 8, 1'b0)));
      end

      // Exhaustive sweep with popcount preservation.
      for (int ai = 0; ai < 256; ai++) begin
         for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < 2; d++) begin
               a = 8'(ai); amt = 3'(k); direction = 1'(d);
               @(posedge clk); #1;
               check("exhaustive", 32'(y), 32'(ref_rot(8'(ai), k, 1'(d))));
               check("popcount", 32'($countones(y)), 32'($countones(8'(ai))));
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
